// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and data-memory wait freezes.
// Optional perf counters (stall_cycles, flush_cycles) are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int BR_EXTRA    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs,
  input  logic        id_uses_rs2,
  input  logic        id_ex_memrd,
  input  logic [4:0]  id_ex_rd,
  input  logic        ex_br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_freeze,
  output logic        mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] LU_CNT = 4'(LOAD_LAT - 1);
  localparam logic [3:0] BR_CNT = 4'(BR_EXTRA);
  localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       timeout_q;
  logic       frz, lu, timeout_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign frz = dmem_req & ~dmem_ready;
  assign lu  = id_ex_memrd & (id_ex_rd != 5'd0) &
               ((id_uses_rs & (id_ex_rd == id_rs)) | (id_uses_rs2 & (id_ex_rd == id_rs2)));

  assign wait_nxt    = sat_inc8(wait_cnt);
  // Visible in the very freeze cycle that reaches the limit, sticky afterwards.
  assign timeout_hit = frz & (wait_nxt >= TO_LIM);
  assign mem_timeout = rst_n & (timeout_q | timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= 4'd0;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wait_cnt  <= frz ? wait_nxt : 8'd0;
      timeout_q <= timeout_q | timeout_hit;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      state_nxt = RUN;
      cnt_nxt   = 4'd0;
    end else if (frz) begin
      // Sequencer state holds so a pending stall/flush resumes after the wait.
      pipe_freeze = 1'b1;
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (BR_EXTRA > 0) begin
              state_nxt = FLUSH;
              cnt_nxt   = BR_CNT;
            end
          end else if (lu) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LU_STALL;
              cnt_nxt   = LU_CNT;
            end
          end
        end
        LU_STALL: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_nxt      = cnt - 4'd1;
          if (cnt <= 4'd1) state_nxt = RUN;
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_nxt      = cnt - 4'd1;
          if (cnt <= 4'd1) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (pc_stall)    stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-parameter instance and a LOAD_LAT=3/BR_EXTRA=2/MEM_TIMEOUT=3
// instance share one stimulus stream; outputs are packed {pc_stall,if_id_stall,if_id_flush,id_ex_bubble,pipe_freeze,mem_timeout}.
module tb_hazard_ctrl;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] STL  = 6'b110100;
  localparam logic [5:0] FLS  = 6'b001100;
  localparam logic [5:0] FRZ  = 6'b110010;
  localparam logic [5:0] MT   = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rs2, id_ex_rd;
  logic       id_uses_rs, id_uses_rs2, id_ex_memrd, ex_br_taken, dmem_req, dmem_ready;
  logic       pc_stall_d, if_id_stall_d, if_id_flush_d, id_ex_bubble_d, pipe_freeze_d, mem_timeout_d;
  logic       pc_stall_p, if_id_stall_p, if_id_flush_p, id_ex_bubble_p, pipe_freeze_p, mem_timeout_p;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_d, flush_cycles_d, stall_cycles_p, flush_cycles_p;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut_d (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs2(id_rs2),
    .id_uses_rs(id_uses_rs), .id_uses_rs2(id_uses_rs2), .id_ex_memrd(id_ex_memrd),
    .id_ex_rd(id_ex_rd), .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall_d), .if_id_stall(if_id_stall_d), .if_id_flush(if_id_flush_d),
    .id_ex_bubble(id_ex_bubble_d), .pipe_freeze(pipe_freeze_d), .mem_timeout(mem_timeout_d)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles_d), .flush_cycles(flush_cycles_d)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .BR_EXTRA(2), .MEM_TIMEOUT(3)) dut_p (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs2(id_rs2),
    .id_uses_rs(id_uses_rs), .id_uses_rs2(id_uses_rs2), .id_ex_memrd(id_ex_memrd),
    .id_ex_rd(id_ex_rd), .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall_p), .if_id_stall(if_id_stall_p), .if_id_flush(if_id_flush_p),
    .id_ex_bubble(id_ex_bubble_p), .pipe_freeze(pipe_freeze_p), .mem_timeout(mem_timeout_p)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles_p), .flush_cycles(flush_cycles_p)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rs2, rd;
    logic       urs, urs2, memrd, br, req, rdy;
    logic [5:0] ed, ep;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] out_d();
    return {pc_stall_d, if_id_stall_d, if_id_flush_d, id_ex_bubble_d, pipe_freeze_d, mem_timeout_d};
  endfunction

  function automatic logic [5:0] out_p();
    return {pc_stall_p, if_id_stall_p, if_id_flush_p, id_ex_bubble_p, pipe_freeze_p, mem_timeout_p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [4:0] rs, input logic [4:0] rs2,
                     input logic urs, input logic urs2, input logic memrd, input logic [4:0] rd,
                     input logic br, input logic req, input logic rdy,
                     input logic [5:0] ed, input logic [5:0] ep);
    vec_t v;
    v.name = name; v.rs = rs; v.rs2 = rs2; v.urs = urs; v.urs2 = urs2; v.memrd = memrd;
    v.rd = rd; v.br = br; v.req = req; v.rdy = rdy; v.ed = ed; v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rs2 = v.rs2; id_uses_rs = v.urs; id_uses_rs2 = v.urs2;
    id_ex_memrd = v.memrd; id_ex_rd = v.rd; ex_br_taken = v.br;
    dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rs2 = 5'd0; id_uses_rs = 1'b0; id_uses_rs2 = 1'b0;
    id_ex_memrd = 1'b0; id_ex_rd = 5'd0; ex_br_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic step_chk(input string name, input logic br, input logic req, input logic rdy,
                          input logic [5:0] ed, input logic [5:0] ep);
    @(posedge clk); #1;
    idle();
    ex_br_taken = br; dmem_req = req; dmem_ready = rdy;
    @(negedge clk);
    chk({name, "_d"}, 32'(out_d()), 32'(ed));
    chk({name, "_p"}, 32'(out_p()), 32'(ep));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //  name        rs  rs2 urs urs2 mrd rd br req rdy  exp_default  exp_param
    add("idle",      0,  0,  0,  0,  0,  0, 0, 0, 1, IDLE,     IDLE);
    add("lu_rs",     5,  0,  1,  0,  1,  5, 0, 0, 1, STL,      STL);
    add("lu_br_ign", 0,  0,  0,  0,  0,  0, 1, 0, 1, FLS,      STL);
    add("lu_tail",   0,  0,  0,  0,  0,  0, 0, 0, 1, FLS,      STL);
    add("back_run",  0,  0,  0,  0,  0,  0, 0, 0, 1, IDLE,     IDLE);
    add("rd_zero",   0,  0,  1,  0,  1,  0, 0, 0, 1, IDLE,     IDLE);
    add("no_load",   5,  0,  1,  0,  0,  5, 0, 0, 1, IDLE,     IDLE);
    add("rs_unused", 7,  3,  0,  1,  1,  7, 0, 0, 1, IDLE,     IDLE);
    add("br_and_lu", 0,  7,  0,  1,  1,  7, 1, 0, 1, FLS,      FLS);
    add("frz1",      0,  0,  0,  0,  0,  0, 0, 1, 0, FRZ,      FRZ);
    add("frz2",      0,  0,  0,  0,  0,  0, 0, 1, 0, FRZ,      FRZ);
    add("frz3",      0,  0,  0,  0,  0,  0, 0, 1, 0, FRZ,      FRZ | MT);
    add("frz4",      0,  0,  0,  0,  0,  0, 0, 1, 0, FRZ,      FRZ | MT);
    add("mem_done",  0,  0,  0,  0,  0,  0, 0, 1, 1, FLS,      FLS | MT);
    add("fl_tail",   0,  0,  0,  0,  0,  0, 0, 0, 1, IDLE,     FLS | MT);
    add("sticky",    0,  0,  0,  0,  0,  0, 0, 0, 1, IDLE,     MT);

    // Reset with a load-use match on the inputs: every output must still read 0.
    rst_n = 1'b0;
    idle();
    id_ex_memrd = 1'b1; id_ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; ex_br_taken = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_d", 32'(out_d()), 32'(IDLE));
    chk("reset_p", 32'(out_p()), 32'(IDLE));
`ifdef HAZ_PERF_CNT_EN
    chk("reset_stall_cnt", stall_cycles_p, 32'd0);
    chk("reset_flush_cnt", flush_cycles_p, 32'd0);
`endif
    idle();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_d"}, 32'(out_d()), 32'(vecs[i].ed));
      chk({vecs[i].name, "_p"}, 32'(out_p()), 32'(vecs[i].ep));
    end

    // Asynchronous reset in the middle of a LOAD_LAT=3 stall.
    @(posedge clk); #1;
    idle();
    id_ex_memrd = 1'b1; id_ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    @(negedge clk);
    chk("mid_lu_start_p", 32'(out_p()), 32'(STL | MT));
    @(posedge clk); #1;
    idle();
    #1;
    chk("mid_lu_hold_p", 32'(out_p()), 32'(STL | MT));
    rst_n = 1'b0;
    #1;
    chk("async_rst_d", 32'(out_d()), 32'(IDLE));
    chk("async_rst_p", 32'(out_p()), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step_chk("post_rst_run", 1'b0, 1'b0, 1'b1, IDLE, IDLE);

    // Five-cycle freeze: timeout rises on the third cycle for the MEM_TIMEOUT=3 instance.
    step_chk("to_frz1", 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    step_chk("to_frz2", 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    step_chk("to_frz3", 1'b0, 1'b1, 1'b0, FRZ, FRZ | MT);
    step_chk("to_frz4", 1'b0, 1'b1, 1'b0, FRZ, FRZ | MT);
    step_chk("to_frz5", 1'b0, 1'b1, 1'b0, FRZ, FRZ | MT);
    step_chk("to_br",   1'b1, 1'b0, 1'b1, FLS, FLS | MT);
    step_chk("to_fl1",  1'b0, 1'b0, 1'b1, FLS, FLS | MT);
    step_chk("to_fl2",  1'b0, 1'b0, 1'b1, IDLE, FLS | MT);
    step_chk("to_end",  1'b0, 1'b0, 1'b1, IDLE, MT);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt_p", stall_cycles_p, 32'd5);
    chk("flush_cnt_p", flush_cycles_p, 32'd3);
    chk("stall_cnt_d", stall_cycles_d, 32'd5);
    chk("flush_cnt_d", flush_cycles_d, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
